instr_fetch_unit: RTL and testbench

//  Consumer side of the PC register: accepts fetch addresses from the PC stage,

---
 rtl/instr_fetch_unit.sv | 177 +++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: single-outstanding instruction fetch feeding a small
// {pc, instr} FIFO toward decode. Optional macro FETCH_ALIGN_CHECK_EN.
module instr_fetch_unit #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] pc_in,
    input  logic          pc_valid,
    output logic          pc_ready,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [DW-1:0] imem_rdata,
    input  logic          flush,
    output logic          if_valid,
    output logic [AW-1:0] if_pc,
    output logic [DW-1:0] if_instr,
    output logic          if_fault,
    input  logic          id_ready
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [AW-1:0] pc_mem    [DEPTH];
    logic [DW-1:0] instr_mem [DEPTH];

    logic          not_full;
    logic          accept;
    logic          push;
    logic          pop;
    logic [AW-1:0] push_pc;
    logic [DW-1:0] push_instr;

`ifdef FETCH_ALIGN_CHECK_EN
    logic fault_mem [DEPTH];
    logic push_fault;
    logic misaligned;

    assign misaligned = (pc_in[1:0] != 2'b00);
`else
    logic unused_pc_lsb;

    assign unused_pc_lsb = ^pc_in[1:0];
`endif

    assign not_full = (count_q < FULL);
    assign pc_ready = (state_q == IDLE) && not_full && !flush;
    assign accept   = pc_valid && pc_ready;
    assign if_valid = (count_q != '0);
    assign pop      = if_valid && id_ready && !flush;

    // Fetch FSM: next state, request address and FIFO push selection.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        push       = 1'b0;
        push_pc    = addr_q;
        push_instr = imem_rdata;
`ifdef FETCH_ALIGN_CHECK_EN
        push_fault = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (accept) begin
`ifdef FETCH_ALIGN_CHECK_EN
                    if (misaligned) begin
                        push       = 1'b1;
                        push_pc    = pc_in;
                        push_instr = '0;
                        push_fault = 1'b1;
                    end else begin
                        addr_d  = pc_in;
                        state_d = WAIT;
                    end
`else
                    addr_d  = {pc_in[AW-1:2], 2'b00};
                    state_d = WAIT;
`endif
                end
            end
            WAIT: begin
                if (imem_ack) begin
                    push    = !flush;
                    state_d = IDLE;
                end else if (flush) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (imem_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO bookkeeping; flush empties the queue and rewinds both pointers.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // State, request address and FIFO pointer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage; the slot was reserved at accept so it is never full here.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            pc_mem[wr_ptr_q]    <= push_pc;
            instr_mem[wr_ptr_q] <= push_instr;
`ifdef FETCH_ALIGN_CHECK_EN
            fault_mem[wr_ptr_q] <= push_fault;
`endif
        end
    end

    assign imem_req  = (state_q != IDLE);
    assign imem_addr = addr_q;
    assign if_pc     = if_valid ? pc_mem[rd_ptr_q] : '0;
    assign if_instr  = if_valid ? instr_mem[rd_ptr_q] : '0;
`ifdef FETCH_ALIGN_CHECK_EN
    assign if_fault  = if_valid ? fault_mem[rd_ptr_q] : 1'b0;
`else
    assign if_fault  = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: random stimulus, transaction-level model and
// scoreboard for instr_fetch_unit.
module tb_instr_fetch_unit;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;
`ifdef FETCH_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] pc_in;
    logic          pc_valid;
    logic          pc_ready;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [DW-1:0] imem_rdata;
    logic          flush;
    logic          if_valid;
    logic [AW-1:0] if_pc;
    logic [DW-1:0] if_instr;
    logic          if_fault;
    logic          id_ready;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .DEPTH(DEPTH),
        .AW   (AW),
        .DW   (DW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pc_in     (pc_in),
        .pc_valid  (pc_valid),
        .pc_ready  (pc_ready),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_rdata(imem_rdata),
        .flush     (flush),
        .if_valid  (if_valid),
        .if_pc     (if_pc),
        .if_instr  (if_instr),
        .if_fault  (if_fault),
        .id_ready  (id_ready)
    );

    typedef struct {
        logic [AW-1:0] pc;
        logic [DW-1:0] instr;
        logic          fault;
    } entry_t;

    entry_t        exp_q[$];
    int            total = 0;
    int            bad = 0;
    logic          busy = 1'b0;
    logic          drop = 1'b0;
    logic          rst_seen = 1'b0;
    logic          accept_nxt = 1'b0;
    logic          exp_ready;
    logic [AW-1:0] cur_addr = '0;
    logic [AW-1:0] seq_pc = '0;
    int            mem_max = 1;
    int            mem_wait = -1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a fetch accepted while nothing is outstanding yields
    // one entry when its data returns, unless a flush or reset came first.
    initial forever begin
        @(posedge clk);
        if (reset) begin
            exp_q.delete();
            busy     = 1'b0;
            drop     = 1'b0;
            rst_seen = 1'b1;
        end else begin
            rst_seen = 1'b0;
            if (flush) begin
                exp_q.delete();
                if (busy) begin
                    if (imem_ack) begin
                        busy = 1'b0;
                        drop = 1'b0;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end else begin
                if (busy && imem_ack) begin
                    if (!drop) exp_q.push_back('{cur_addr, imem_rdata, 1'b0});
                    busy = 1'b0;
                    drop = 1'b0;
                end
                if (accept_nxt) begin
                    if (ALIGN && pc_in[1:0] != 2'b00) begin
                        exp_q.push_back('{pc_in, '0, 1'b1});
                    end else begin
                        busy     = 1'b1;
                        cur_addr = ALIGN ? pc_in : {pc_in[AW-1:2], 2'b00};
                    end
                end
            end
        end
    end

    // Monitor: compare DUT outputs mid-cycle and retire consumed entries.
    initial forever begin
        @(negedge clk);
        if (rst_seen) begin
            check("rst_imem_addr", imem_addr, '0);
            check("rst_if_pc", if_pc, '0);
            check("rst_if_instr", if_instr, '0);
            check("rst_if_fault", 32'(if_fault), '0);
        end
        exp_ready = !busy && (exp_q.size() < DEPTH) && !flush;
        check("pc_ready", 32'(pc_ready), 32'(exp_ready));
        check("imem_req", 32'(imem_req), 32'(busy));
        if (busy) check("imem_addr", imem_addr, cur_addr);
        check("if_valid", 32'(if_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            check("if_pc", if_pc, exp_q[0].pc);
            check("if_instr", if_instr, exp_q[0].instr);
            check("if_fault", 32'(if_fault), 32'(exp_q[0].fault));
            if (id_ready && !flush && !reset) void'(exp_q.pop_front());
        end
        accept_nxt = pc_valid && exp_ready;
    end

    // Instruction memory: acks each request after 0..mem_max cycles.
    initial begin
        imem_ack   = 1'b0;
        imem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            imem_ack = 1'b0;
            if (mem_wait < 0 && imem_req) mem_wait = $urandom_range(0, mem_max);
            if (mem_wait == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = $urandom;
                mem_wait   = -1;
            end else if (mem_wait > 0) begin
                mem_wait--;
            end
        end
    end

    task automatic drive(input int n, input int valid_pct, input int rdy_pct,
                         input int flush_pct, input int rst_pct, input int dly);
        mem_max = dly;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (accept_nxt) begin
                seq_pc = seq_pc + 32'd4;
                if ($urandom_range(0, 7) == 0) seq_pc = $urandom & 32'hFFFF_FFF0;
            end
            pc_in = seq_pc;
            if ($urandom_range(0, 9) == 0) pc_in = seq_pc | 32'($urandom_range(1, 3));
            pc_valid = ($urandom_range(0, 99) < valid_pct);
            id_ready = ($urandom_range(0, 99) < rdy_pct);
            flush    = ($urandom_range(0, 99) < flush_pct);
            reset    = ($urandom_range(0, 99) < rst_pct);
        end
    endtask

    initial begin
        reset    = 1'b1;
        pc_valid = 1'b0;
        pc_in    = '0;
        flush    = 1'b0;
        id_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        drive(200, 60, 100, 0, 0, 1);
        drive(30, 100, 0, 0, 0, 0);
        drive(20, 0, 100, 0, 0, 0);
        drive(600, 70, 60, 15, 0, 4);
        drive(600, 70, 60, 5, 3, 4);
        drive(40, 0, 100, 0, 0, 0);
        @(negedge clk);
        check("drained", 32'(exp_q.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
